// File: rtl/muldiv_pkg.sv
// Shared types for the iterative unsigned multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU, one shift-add or restore-subtract step per cycle.
// Optional zero-operand early-out is enabled by defining MULDIV_EARLY_OUT_EN.
//
//   state  | meaning
//   S_IDLE | waiting for start; operands latched on accept
//   S_CALC | n iteration steps, one per cycle
//   S_DONE | result on wb_data, wb_en pulsed unless dest is x0
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int n = 32,
    parameter int r = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [r-1:0] dest,
    output logic         busy,
    output logic         wb_en,
    output logic [r-1:0] wb_addr,
    output logic [n-1:0] wb_data
);

    localparam int CW = $clog2(n) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(n - 1);

    state_t           state;
    op_t              op_q;
    logic [r-1:0]     dest_q;
    logic [n-1:0]     a_q;
    logic [n-1:0]     b_q;
    logic [2*n-1:0]   prod;
    logic [n:0]       rem;
    logic [n-1:0]     quo;
    logic [CW-1:0]    cnt;

    logic [n:0]       add_sum;
    logic [2*n-1:0]   prod_nx;
    logic [n:0]       rem_sh;
    logic [n+1:0]     rem_diff;
    logic [n:0]       rem_nx;
    logic [n-1:0]     quo_nx;
    logic [n-1:0]     result;

    // Product register holds the running high half above the not-yet-consumed bits of B.
    always_comb begin
        add_sum  = {1'b0, prod[2*n-1:n]} + (prod[0] ? {1'b0, a_q} : '0);
        prod_nx  = {add_sum, prod[n-1:1]};
        rem_sh   = {rem[n-1:0], quo[n-1]};
        rem_diff = {1'b0, rem_sh} - {2'b00, b_q};
        if (!rem_diff[n+1]) begin
            rem_nx = rem_diff[n:0];
            quo_nx = {quo[n-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh;
            quo_nx = {quo[n-2:0], 1'b0};
        end
        result = '0;
        case (op_q)
            OP_MUL:   result = prod_nx[n-1:0];
            OP_MULHU: result = prod_nx[2*n-1:n];
            OP_DIVU:  result = quo_nx;
            OP_REMU:  result = rem_nx[n-1:0];
            default:  result = '0;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic         early;
    logic [n-1:0] early_res;

    // With a zero operand the remainder is always a, and the quotient is all ones only for b==0.
    always_comb begin
        early     = (a == '0) || (b == '0);
        early_res = '0;
        case (op_t'(op))
            OP_DIVU: early_res = (b == '0) ? '1 : '0;
            OP_REMU: early_res = a;
            default: early_res = '0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            op_q    <= OP_MUL;
            dest_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod    <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op_t'(op);
                        dest_q <= dest;
                        a_q    <= a;
                        b_q    <= b;
                        prod   <= {{n{1'b0}}, b};
                        rem    <= '0;
                        quo    <= a;
                        cnt    <= '0;
`ifdef MULDIV_EARLY_OUT_EN
                        if (early) begin
                            state   <= S_DONE;
                            wb_data <= early_res;
                            wb_addr <= dest;
                            wb_en   <= (dest != '0);
                        end else begin
                            state <= S_CALC;
                        end
`else
                        state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    prod <= prod_nx;
                    rem  <= rem_nx;
                    quo  <= quo_nx;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state   <= S_DONE;
                        wb_data <= result;
                        wb_addr <= dest_q;
                        wb_en   <= (dest_q != '0);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations against an arithmetic model.
// Latency expectations follow MULDIV_EARLY_OUT_EN when it is defined for the build.
module tb_muldiv_unit;

    localparam int N = 32;
    localparam int R = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [R-1:0] dest;
    logic         busy;
    logic         wb_en;
    logic [R-1:0] wb_addr;
    logic [N-1:0] wb_data;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] regs [32];

    muldiv_unit #(.n(N), .r(R)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .dest    (dest),
        .busy    (busy),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    always #5 clk = ~clk;

    // Bench-side register file fed by the write port.
    always @(posedge clk) begin
        if (wb_en) regs[wb_addr] <= wb_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        case (o)
            2'b00:   return p[N-1:0];
            2'b01:   return p[2*N-1:N];
            2'b10:   return (y == 0) ? {N{1'b1}} : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int latency(input logic [N-1:0] x, input logic [N-1:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        if (x == 0 || y == 0) return 1;
`endif
        return N + 1;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [N-1:0] x,
                          input logic [N-1:0] y, input logic [R-1:0] d, input bit poke);
        int lat, span, busy_cnt, wen_cnt, wen_at;
        logic [N-1:0] expv, got_data;
        logic [R-1:0] got_addr;
        logic last_busy;
        lat      = latency(x, y);
        expv     = model(o, x, y);
        span     = lat + 1 + (poke ? 40 : 0);
        busy_cnt = 0;
        wen_cnt  = 0;
        wen_at   = -1;
        got_data = '0;
        got_addr = '0;
        last_busy = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; dest = d;
        for (int k = 1; k <= span; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (k == lat + 1) last_busy = busy;
            if (wb_en) begin
                wen_cnt++;
                wen_at   = k;
                got_data = wb_data;
                got_addr = wb_addr;
            end
            if (k == 1) begin
                start = 1'b0;
                a = $urandom;
                b = $urandom;
            end
            if (poke && k == 10) start = 1'b1;
            if (poke && k == 11) start = 1'b0;
        end
        check({tag, "_busy_cycles"}, busy_cnt, lat);
        check({tag, "_busy_drop"}, last_busy, 0);
        if (d != 0) begin
            check({tag, "_wen_count"}, wen_cnt, 1);
            check({tag, "_wen_cycle"}, wen_at, lat);
            check({tag, "_data"}, got_data, expv);
            check({tag, "_addr"}, got_addr, d);
            check({tag, "_hold"}, wb_data, expv);
        end else begin
            check({tag, "_no_wen"}, wen_cnt, 0);
        end
    endtask

    initial begin
        int wen_cnt;
        logic [1:0]   ro;
        logic [N-1:0] ra, rb;
        logic [R-1:0] rd;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; dest = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_wen", wb_en, 0);
        check("rst_data", wb_data, 0);
        check("rst_addr", wb_addr, 0);
        rst = 1'b1;

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd3, 1'b0);
        check("regfile_x3", regs[3], 42);
        run_op("mulhu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
        check("mulhu_max_val", regs[4], 32'hFFFF_FFFE);
        run_op("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b0);
        check("mul_max_val", regs[5], 32'h0000_0001);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 5'd6, 1'b0);
        check("divu_val", regs[6], 14);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd7, 1'b0);
        check("remu_val", regs[7], 2);
        run_op("divu_by0", 2'b10, 32'd5, 32'd0, 5'd8, 1'b0);
        check("divu_by0_val", regs[8], 32'hFFFF_FFFF);
        run_op("remu_by0", 2'b11, 32'd5, 32'd0, 5'd9, 1'b0);
        check("remu_by0_val", regs[9], 5);
        run_op("mul_x0_poke", 2'b00, 32'd3, 32'd3, 5'd0, 1'b1);

        // Reset in the middle of a divide discards it.
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7; dest = 5'd12;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_wen", wb_en, 0);
        check("midrst_data", wb_data, 0);
        check("midrst_addr", wb_addr, 0);
        rst = 1'b1;
        wen_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wb_en) wen_cnt++;
        end
        check("midrst_no_wb", wen_cnt, 0);
        check("midrst_x12", regs[12], 0);
        run_op("after_rst", 2'b10, 32'd1000, 32'd7, 5'd12, 1'b0);

        run_op("mul_zero_a", 2'b00, 32'd0, 32'd9, 5'd10, 1'b0);
        run_op("divu_zero_a", 2'b10, 32'd0, 32'd5, 5'd11, 1'b0);
        run_op("remu_zero_a", 2'b11, 32'd0, 32'd5, 5'd13, 1'b0);
        run_op("mulhu_zero_b", 2'b01, 32'd77, 32'd0, 5'd14, 1'b0);

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = $urandom_range(0, 20);
            if (i % 8 == 3) rb = '0;
            rd = 5'($urandom_range(1, 31));
            run_op("rand", ro, ra, rb, rd, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative unsigned multiply/divide unit on the register-file write side of the datapath.
- Operands come from the regfile read ports (read_data1/read_data2).
- Results drive the regfile write port (write_addr/write_data/write_en) through wb_addr/wb_data/wb_en.
- Uses one shift-add or restore-subtract step per cycle, so an n-bit operation costs n cycles instead of a large combinational array.

Parameters:
- n, 32: operand/result bit width; matches regfile n.
- r, 5: destination register address width; matches regfile r.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low (rst==0 at a rising edge resets).
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 MUL (low n bits), 01 MULHU (high n bits), 10 DIVU (quotient), 11 REMU (remainder).
- a  input  n  operand A / dividend (from read_data1).
- b  input  n  operand B / divisor (from read_data2).
- dest  input  r  destination register address.
- busy  output  1  high whenever state != IDLE.
- wb_en  output  1  one-cycle write strobe to regfile write_en.
- wb_addr  output  r  registered dest; to regfile write_addr.
- wb_data  output  n  result; to regfile write_data.

Behaviour:
- FSM states: IDLE, CALC, DONE.
- IDLE -> CALC when start=1.
  - Latch a, b, op and dest.
  - Clear the accumulator/remainder.
  - Set the step counter to 0. Counter width is $clog2(n)+1.
- CALC: performs one iteration per cycle for exactly n cycles, then goes to DONE.
  - MUL/MULHU: shift-add, LSB-first over B; 2n-bit product register.
  - DIVU/REMU: restoring division, MSB-first; n-bit quotient and (n+1)-bit partial remainder.
  - All arithmetic is unsigned; no signed ops in this block.
- DONE: wb_en=1 for exactly this cycle, then IDLE on the next edge.
  - wb_addr = latched dest.
  - wb_data = selected result.
- Latency: start sampled at edge t.
  - wb_en high during cycle t+n+1.
  - busy high over cycles t+1..t+n+1.
  - A new start is accepted at edge t+n+2 at the earliest.
- Registered outputs; nothing combinational from inputs to outputs.
- Between operations, wb_data and wb_addr hold their last values; wb_en=0 outside DONE.
- start while busy: ignored, no queueing; a and b may change freely during CALC.
- Divide by zero (b==0): DIVU yields all ones (2^n-1); REMU yields a. Latency is unchanged (n CALC cycles).
- dest==0: the operation runs with full latency, but wb_en stays 0 in DONE (x0 is never written).
- Reset (rst==0 at any edge, including mid-CALC or in DONE):
  - state=IDLE, busy=0, wb_en=0, wb_addr=0, wb_data=0, counter=0.
  - The in-flight operation is discarded with no writeback.
- op values are all legal; no error output.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: when a==0 or b==0 at start, go IDLE -> DONE directly, skipping CALC. wb_en is then high in cycle t+1. Results:
  - MUL/MULHU with a zero operand -> 0.
  - DIVU with b==0 -> all ones.
  - REMU with b==0 -> a.
  - DIVU/REMU with a==0 and b!=0 -> 0.
- Undefined: fixed n-cycle latency for every operation; no early-out logic present.

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum logic [1:0] op_t {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
  - typedef enum logic [1:0] state_t {S_IDLE, S_CALC, S_DONE}.
- No sub-module. The shift-add and restore-subtract step datapaths stay inline in the single module; block size does not justify a split.

Test Plan:
- MUL a=7, b=6, dest=3 -> wb_en pulse in cycle t+33, wb_addr=3, wb_data=42; busy high for 33 cycles; writes land in the regfile, read back as 42.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> wb_data=0xFFFFFFFE. MUL on the same operands -> wb_data=0x00000001.
- DIVU a=100, b=7 -> 14; REMU a=100, b=7 -> 2. DIVU a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5. Each with a 33-cycle latency (macro off).
- dest=0 with MUL 3*3 -> busy sequence normal, wb_en never asserted. A second start pulsed at t+10 -> ignored, exactly one DONE.
- rst=0 at t+15 of a DIVU -> next cycle busy=0, wb_en=0, wb_data=0, and no writeback ever appears. A new start after rst=1 completes normally.
- With MULDIV_EARLY_OUT_EN: MUL a=0, b=9 -> wb_en in cycle t+1 with wb_data=0. DIVU 100/7 still takes 33 cycles.
